prog_load_ctrl: RTL and testbench

PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

---
 rtl/prog_load_ctrl.sv | 146 ++++++++++++++
 tb/tb_prog_load_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: loads a header-framed word stream into imem (128-bit lines) and dmem (32-bit words),
// holding the core in reset until the load completes.
module prog_load_ctrl #(
   parameter int          ADDR_LEN       = 32,
   parameter logic [31:0] DMEM_BASE      = 32'h0,
   parameter int          IMEM_MAX_LINES = 512,
   parameter int          DMEM_MAX_WORDS = 2048
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [31:0]         in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [ADDR_LEN-1:0] load_addr,
   output logic [127:0]        load_data,
   output logic                we_128,
   output logic                we_32,
   output logic                core_hold,
   output logic                done,
   output logic                error
);
   typedef enum logic [2:0] {IDLE, HDR_I, HDR_D, LOAD_I, PAD, LOAD_D, DONE, ERR} state_t;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [33:0] IMEM_MAX_WORDS = 34'(IMEM_MAX_LINES) << 2;
   state_t state_q, state_d;
   logic [31:0] ni_q, ni_d, nd_q, nd_d, cnt_q, cnt_d;
   logic [127:0] line_q, line_d, load_data_q, load_data_d, line_ins, line_pad;
   logic [ADDR_LEN-1:0] load_addr_q, load_addr_d, line_addr, dmem_addr;
   logic we_128_q, we_128_d, we_32_q, we_32_d, in_ready_q, in_ready_d;
   logic done_q, done_d, error_q, error_d, core_hold_q, core_hold_d;
   logic hs;
   logic [1:0] slot;
   assign hs        = in_valid & in_ready_q;
   assign slot      = cnt_q[1:0];
   assign line_addr = ADDR_LEN'({cnt_q[31:2], 4'b0});
   assign dmem_addr = ADDR_LEN'(34'(DMEM_BASE) + {cnt_q, 2'b0});
   always_comb begin
      line_ins = line_q;
      line_ins[{slot, 5'b0} +: 32] = in_data;
      line_pad = line_q;
      for (int i = 0; i < 4; i++)
         if (2'(i) >= slot) line_pad[i*32 +: 32] = NOP;
   end
   always_comb begin
      state_d     = state_q;
      ni_d        = ni_q;
      nd_d        = nd_q;
      cnt_d       = cnt_q;
      line_d      = line_q;
      load_addr_d = load_addr_q;
      load_data_d = load_data_q;
      we_128_d    = 1'b0;
      we_32_d     = 1'b0;
      case (state_q)
         IDLE, DONE, ERR: if (start) begin
            state_d = HDR_I;
            cnt_d   = '0;
            line_d  = '0;
         end
         HDR_I: if (hs) begin
            ni_d    = in_data;
            state_d = HDR_D;
         end
         HDR_D: if (hs) begin
            nd_d    = in_data;
            state_d = ({2'b0, ni_q} > IMEM_MAX_WORDS || in_data > 32'(DMEM_MAX_WORDS)) ? ERR :
                      ni_q != 0 ? LOAD_I : in_data != 0 ? LOAD_D : DONE;
         end
         LOAD_I: if (hs) begin
            cnt_d  = cnt_q + 32'd1;
            line_d = line_ins;
            if (slot == 2'd3) begin
               we_128_d    = 1'b1;
               load_addr_d = line_addr;
               load_data_d = line_ins;
               line_d      = '0;
            end
            if (cnt_q == ni_q - 32'd1) begin
               // a partial last line keeps cnt so PAD knows which slots to fill
               state_d = slot != 2'd3 ? PAD : nd_q != 0 ? LOAD_D : DONE;
               if (slot == 2'd3) cnt_d = '0;
            end
         end
         PAD: begin
            we_128_d    = 1'b1;
            load_addr_d = line_addr;
            load_data_d = line_pad;
            line_d      = '0;
            cnt_d       = '0;
            state_d     = nd_q != 0 ? LOAD_D : DONE;
         end
         LOAD_D: if (hs) begin
            we_32_d     = 1'b1;
            load_addr_d = dmem_addr;
            load_data_d = {in_data, 96'b0};
            cnt_d       = cnt_q + 32'd1;
            if (cnt_q == nd_q - 32'd1) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = state_d inside {HDR_I, HDR_D, LOAD_I, LOAD_D};
      done_d      = state_q == DONE && state_d == DONE;
      error_d     = state_q == ERR && state_d == ERR;
      core_hold_d = !done_d;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ni_q        <= '0;
         nd_q        <= '0;
         cnt_q       <= '0;
         line_q      <= '0;
         load_addr_q <= '0;
         load_data_q <= '0;
         we_128_q    <= 1'b0;
         we_32_q     <= 1'b0;
         in_ready_q  <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         core_hold_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         ni_q        <= ni_d;
         nd_q        <= nd_d;
         cnt_q       <= cnt_d;
         line_q      <= line_d;
         load_addr_q <= load_addr_d;
         load_data_q <= load_data_d;
         we_128_q    <= we_128_d;
         we_32_q     <= we_32_d;
         in_ready_q  <= in_ready_d;
         done_q      <= done_d;
         error_q     <= error_d;
         core_hold_q <= core_hold_d;
      end
   end
   assign in_ready  = in_ready_q;
   assign load_addr = load_addr_q;
   assign load_data = load_data_q;
   assign we_128    = we_128_q;
   assign we_32     = we_32_q;
   assign core_hold = core_hold_q;
   assign done      = done_q;
   assign error     = error_q;
endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb_prog_load_ctrl: directed scenarios for prog_load_ctrl with hand-computed expected writes.
module tb_prog_load_ctrl;
   logic clk = 1'b0, reset, start, in_valid;
   logic [31:0] in_data;
   logic in_ready, we_128, we_32, core_hold, done, error;
   logic [31:0] load_addr;
   logic [127:0] load_data;
   int checks = 0, errors = 0, stalls = 0;
   bit both_hi = 1'b0;
   typedef struct {bit wide; logic [31:0] addr; logic [127:0] data;} wr_t;
   wr_t wr[$];

   prog_load_ctrl #(.ADDR_LEN(32), .DMEM_BASE(32'h1000), .IMEM_MAX_LINES(512), .DMEM_MAX_WORDS(2048)) dut (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .load_addr(load_addr), .load_data(load_data), .we_128(we_128), .we_32(we_32),
      .core_hold(core_hold), .done(done), .error(error));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      wr_t e;
      if (we_128 && we_32) both_hi = 1'b1;
      if (we_128 || we_32) begin
         e.wide = we_128;
         e.addr = load_addr;
         e.data = load_data;
         wr.push_back(e);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task pulse_start;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task send(input logic [31:0] w);
      int n;
      in_valid = 1'b1;
      in_data  = w;
      n = 0;
      while (!in_ready && n < 8) begin
         stalls++;
         n++;
         @(negedge clk);
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL handshake word %h in_ready=%b want 1", w, in_ready);
      end
      @(negedge clk);
   endtask

   task test_reset;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      #2;
      checks++;
      if ({in_ready, we_128, we_32, done, error, core_hold} !== 6'b000001 || load_addr !== 0 || load_data !== 0) begin
         errors++;
         $display("FAIL reset_values got rdy%b w128%b w32%b dn%b er%b hold%b a%h d%h want 0,0,0,0,0,1,0,0",
                  in_ready, we_128, we_32, done, error, core_hold, load_addr, load_data);
      end
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || core_hold !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got rdy%b hold%b done%b want 0,1,0", in_ready, core_hold, done);
      end
      in_valid = 1'b0;
   endtask

   task test_imem8;
      wr.delete();
      pulse_start();
      send(8); send(0);
      stalls = 0;
      for (int w = 1; w <= 4; w++) send(w);
      checks++;
      if (we_128 !== 1'b1 || load_addr !== 0) begin
         errors++;
         $display("FAIL imem8_latency got we128=%b addr=%h want 1/0", we_128, load_addr);
      end
      for (int w = 5; w <= 8; w++) send(w);
      in_valid = 1'b0;
      checks++;
      if (we_128 !== 1'b1 || load_addr !== 32'd16 || done !== 1'b0) begin
         errors++;
         $display("FAIL imem8_last_write got we128=%b addr=%h done=%b want 1/10/0", we_128, load_addr, done);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || core_hold !== 1'b0 || in_ready !== 1'b0 || stalls !== 0) begin
         errors++;
         $display("FAIL imem8_done got done=%b hold=%b rdy=%b stalls=%0d want 1/0/0/0", done, core_hold, in_ready, stalls);
      end
      #1;
      checks++;
      if (wr.size() != 2) begin
         errors++;
         $display("FAIL imem8_writes got %0d want 2", wr.size());
      end else begin
         checks++;
         if (!wr[0].wide || wr[0].addr !== 0 || wr[0].data !== {32'd4, 32'd3, 32'd2, 32'd1} ||
             !wr[1].wide || wr[1].addr !== 32'd16 || wr[1].data !== {32'd8, 32'd7, 32'd6, 32'd5}) begin
            errors++;
            $display("FAIL imem8_lines got %h@%h %h@%h want 4_3_2_1@0 8_7_6_5@10",
                     wr[0].data, wr[0].addr, wr[1].data, wr[1].addr);
         end
      end
   endtask

   task test_pad;
      wr.delete();
      pulse_start();
      send(5); send(2);
      for (int w = 1; w <= 5; w++) send(w);
      checks++;
      if (in_ready !== 1'b0 || we_128 !== 1'b0) begin
         errors++;
         $display("FAIL pad_bubble got rdy=%b we128=%b want 0/0", in_ready, we_128);
      end
      stalls = 0;
      send(32'hA0);
      checks++;
      if (we_32 !== 1'b1 || we_128 !== 1'b0 || load_addr !== 32'h1000 || load_data !== {32'hA0, 96'b0} || stalls !== 1) begin
         errors++;
         $display("FAIL pad_dmem0 got we32=%b we128=%b addr=%h data=%h stalls=%0d want 1/0/1000/a0../1",
                  we_32, we_128, load_addr, load_data, stalls);
      end
      send(32'hB1);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || wr.size() != 4) begin
         errors++;
         $display("FAIL pad_done got done=%b writes=%0d want 1/4", done, wr.size());
      end else begin
         checks++;
         if (!wr[1].wide || wr[1].addr !== 32'd16 || wr[1].data !== {32'h13, 32'h13, 32'h13, 32'd5}) begin
            errors++;
            $display("FAIL pad_line got %h@%h want 13_13_13_5@10", wr[1].data, wr[1].addr);
         end
         checks++;
         if (wr[3].wide || wr[3].addr !== 32'h1004 || wr[3].data !== {32'hB1, 96'b0} || wr[0].data !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
            errors++;
            $display("FAIL pad_dmem1 got %h@%h want b1..@1004", wr[3].data, wr[3].addr);
         end
      end
   endtask

   task test_zero;
      wr.delete();
      pulse_start();
      send(0); send(0);
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL zero_state got rdy=%b want 0", in_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || core_hold !== 1'b0 || wr.size() != 0) begin
         errors++;
         $display("FAIL zero_done got done=%b hold=%b writes=%0d want 1/0/0", done, core_hold, wr.size());
      end
   endtask

   task test_error;
      wr.delete();
      pulse_start();
      send(0); send(2049);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (error !== 1'b1 || core_hold !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL err_dmem got err=%b hold=%b done=%b rdy=%b want 1/1/0/0", error, core_hold, done, in_ready);
      end
      pulse_start();
      checks++;
      if (error !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL err_restart got err=%b rdy=%b want 0/1", error, in_ready);
      end
      send(2049); send(0);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (error !== 1'b1) begin
         errors++;
         $display("FAIL err_imem got err=%b want 1", error);
      end
      pulse_start();
      send(4); send(1);
      for (int w = 10; w <= 13; w++) send(w);
      send(99);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || error !== 1'b0 || wr.size() != 2) begin
         errors++;
         $display("FAIL err_reload got done=%b err=%b writes=%0d want 1/0/2", done, error, wr.size());
      end else begin
         checks++;
         if (wr[0].data !== {32'd13, 32'd12, 32'd11, 32'd10} || wr[0].addr !== 0 ||
             wr[1].wide || wr[1].addr !== 32'h1000 || wr[1].data !== {32'd99, 96'b0}) begin
            errors++;
            $display("FAIL err_reload_data got %h@%h %h@%h want d_c_b_a@0 63..@1000", wr[0].data, wr[0].addr, wr[1].data, wr[1].addr);
         end
      end
   endtask

   task test_reset_mid;
      pulse_start();
      send(2048); send(2048);
      checks++;
      if (in_ready !== 1'b1 || error !== 1'b0) begin
         errors++;
         $display("FAIL cap_limit got rdy=%b err=%b want 1/0", in_ready, error);
      end
      for (int w = 1; w <= 4; w++) begin
         send(w);
         if (w < 4) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
      end
      checks++;
      if (we_128 !== 1'b1 || load_data !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
         errors++;
         $display("FAIL gap_line got we128=%b data=%h want 1/4_3_2_1", we_128, load_data);
      end
      reset = 1'b1;
      in_data = 32'd5;
      #1;
      checks++;
      if ({in_ready, we_128, we_32, done, error, core_hold} !== 6'b000001 || load_addr !== 0 || load_data !== 0) begin
         errors++;
         $display("FAIL async_reset got rdy%b w128%b w32%b dn%b er%b hold%b a%h d%h want 0,0,0,0,0,1,0,0",
                  in_ready, we_128, we_32, done, error, core_hold, load_addr, load_data);
      end
      @(negedge clk);
      checks++;
      if (we_128 !== 1'b0 || we_32 !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_strobe got we128=%b we32=%b rdy=%b want 0/0/0", we_128, we_32, in_ready);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      wr.delete();
      pulse_start();
      send(4); send(0);
      for (int w = 21; w <= 24; w++) send(w);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (wr.size() != 1 || wr[0].addr !== 0 || wr[0].data !== {32'd24, 32'd23, 32'd22, 32'd21} || done !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_load got writes=%0d done=%b want 1 write 18_17_16_15@0 done 1", wr.size(), done);
      end
   endtask

   task test_start_in_load_d;
      wr.delete();
      pulse_start();
      send(0); send(3);
      send(32'hC0);
      start = 1'b1;
      send(32'hC1);
      start = 1'b0;
      send(32'hC2);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || wr.size() != 3) begin
         errors++;
         $display("FAIL start_ignored got done=%b writes=%0d want 1/3", done, wr.size());
      end else begin
         for (int j = 0; j < 3; j++) begin
            checks++;
            if (wr[j].wide || wr[j].addr !== 32'h1000 + 32'(4 * j) || wr[j].data !== {32'hC0 + 32'(j), 96'b0}) begin
               errors++;
               $display("FAIL start_ignored_w%0d got %h@%h wide=%b", j, wr[j].data, wr[j].addr, wr[j].wide);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_imem8();
      test_pad();
      test_zero();
      test_error();
      test_reset_mid();
      test_start_in_load_d();
      checks++;
      if (both_hi) begin
         errors++;
         $display("FAIL strobe_overlap got we_128&we_32=1 want never");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
